// File: rtl/mux_pkg.sv
// Shared types and constants for the N:1 scanning mux.
package mux_pkg;
  typedef enum logic {MAN = 1'b0, SCAN = 1'b1} state_t;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  // Select width: at least one bit even for tiny N.
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_scan_ctr.sv
// Round-robin channel counter: holds each channel for DWELL advances, then wraps N-1 -> 0.
module mux_scan_ctr #(
  parameter int N     = 3,
  parameter int DWELL = 4,
  parameter int SW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [SW-1:0] ch,
  output logic          wrap
);
  localparam int DWW = $clog2(DWELL + 1);

  logic [DWW-1:0] dw;

  // Terminal dwell count: the next advance moves to the next channel.
  assign wrap = (dw == DWW'(DWELL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dw <= '0;
      ch <= '0;
    end else if (clr) begin
      dw <= '0;
      ch <= '0;
    end else if (adv) begin
      if (wrap) begin
        dw <= '0;
        ch <= (ch == SW'(N - 1)) ? '0 : ch + 1'b1;
      end else begin
        dw <= dw + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_n_1_scan.sv
// N:1 registered mux with manual select or dwell-based round-robin scan.
module mux_n_1_scan
  import mux_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int N     = 3,
  parameter  int DWELL = 4,
  localparam int SW    = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SW-1:0]      s,
  input  logic [N*WIDTH-1:0] d,
  output logic [WIDTH-1:0]   y,
  output logic [SW-1:0]      y_ch,
  output logic               y_valid,
  output logic               sel_err
);
  state_t         state;
  logic [SW-1:0]  ch;
  logic           wrap;
  logic           entry;
  logic           sel_bad;
  logic [SW-1:0]  sel;
  logic [WIDTH-1:0] pick;

  // State tracks mode every cycle, independent of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MAN;
    else        state <= (mode == MODE_SCAN) ? SCAN : MAN;
  end

  assign entry   = (state == MAN) && (mode == MODE_SCAN);
  assign sel_bad = {1'b0, s} >= (SW + 1)'(N);

  mux_scan_ctr #(.N(N), .DWELL(DWELL), .SW(SW)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (entry),
    .adv   (en && (state == SCAN)),
    .ch    (ch),
    .wrap  (wrap)
  );

  // Out-of-range s is never loaded, so steer it to channel 0 to keep the part-select in bounds.
  always_comb begin
    sel = ch;
    if (state == MAN) sel = sel_bad ? '0 : s;
    pick = d[32'(sel) * WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      sel_err <= 1'b0;
    end else if (en && ((state == SCAN) || !sel_bad)) begin
      y       <= pick;
      y_ch    <= sel;
      y_valid <= 1'b1;
      sel_err <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      sel_err <= en;
    end
  end
endmodule
